// File: rtl/can_rx_pkg.sv
// Shared definitions for the CAN receive path: identifier width, the
// acceptance-filter state encoding and the mask/code match rule.
package can_rx_pkg;

    localparam int unsigned ID_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EOF,
        COMMIT
    } filt_state_t;

    // An ID passes when every bit selected by the mask equals the code bit,
    // or when filtering is disabled.
    function automatic logic id_match(
        input logic            filt_en,
        input logic [ID_W-1:0] id,
        input logic [ID_W-1:0] code,
        input logic [ID_W-1:0] mask
    );
        return !filt_en || (((id ^ code) & mask) == '0);
    endfunction

endpackage

// File: rtl/can_acceptance_filter_fifo.sv
// Synchronous first-word-fall-through FIFO holding accepted identifiers.
// The head word reads as zero while the FIFO is empty.
module accept_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             g_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is allowed only when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL_CNT) || do_pop);
    end

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only observed through head while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Status and head word derived from registered state only.
    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_CNT);
        head  = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/can_acceptance_filter.sv
// CAN receive acceptance filter: snapshots the base ID and its match result
// at the end of arbitration, commits accepted IDs to a FWFT queue only after
// an error-free end of frame, and keeps saturating accept/reject counters.
module can_acceptance_filter
    import can_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             g_rst,
    input  logic [ID_W-1:0]  mask_param,
    input  logic [ID_W-1:0]  code_param,
    input  logic             filt_en,
    input  logic             rx_id_valid,
    input  logic [ID_W-1:0]  rx_id,
    input  logic             rx_frame_ok,
    input  logic             rx_frame_err,
    input  logic             acc_rd,
    output logic             acc_valid,
    output logic [ID_W-1:0]  acc_id,
    output logic             acc_full,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] rej_cnt
);

    filt_state_t     state;
    logic [ID_W-1:0] id_q;
    logic            match_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] fifo_head;
    logic            commit_push;
    logic            commit_drop;

    // In COMMIT a full queue still accepts the ID if the head is popped in the same cycle.
    always_comb begin
        commit_push = 1'b0;
        commit_drop = 1'b0;
        if (state == COMMIT) begin
            commit_push = !fifo_full || acc_rd;
            commit_drop = !commit_push;
        end
    end

    // Frame tracking FSM with the snapshot registers, counters and sticky overflow flag.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            state   <= IDLE;
            id_q    <= '0;
            match_q <= 1'b0;
            acc_cnt <= '0;
            rej_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (commit_push && (acc_cnt != '1)) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (commit_drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_id_valid) begin
                        id_q    <= rx_id;
                        match_q <= id_match(filt_en, rx_id, code_param, mask_param);
                        state   <= WAIT_EOF;
                    end
                end
                WAIT_EOF: begin
                    if (rx_frame_err) begin
                        state <= IDLE;
                    end else if (rx_frame_ok) begin
                        if (match_q) begin
                            state <= COMMIT;
                        end else begin
                            if (rej_cnt != '1) begin
                                rej_cnt <= rej_cnt + 1'b1;
                            end
                            state <= IDLE;
                        end
                    end else if (rx_id_valid) begin
                        id_q    <= rx_id;
                        match_q <= id_match(filt_en, rx_id, code_param, mask_param);
                    end
                end
                COMMIT: begin
                    if (rx_id_valid) begin
                        id_q    <= rx_id;
                        match_q <= id_match(filt_en, rx_id, code_param, mask_param);
                        state   <= WAIT_EOF;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    accept_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(ID_W)
    ) u_fifo (
        .clk  (clk),
        .g_rst(g_rst),
        .push (commit_push),
        .wdata(id_q),
        .pop  (acc_rd),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (fifo_head)
    );

    // Queue status is forwarded straight from the FIFO's registered state.
    always_comb begin
        acc_valid = !fifo_empty;
        acc_full  = fifo_full;
        acc_id    = fifo_head;
    end

endmodule

// File: tb/tb_can_acceptance_filter.sv
// Randomised scoreboard bench for can_acceptance_filter. A transaction-level
// model predicts queue contents, counters and the overflow flag; a separate
// monitor compares every popped head against the expected-ID queue.
module tb_can_acceptance_filter;

    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          g_rst;
    logic [10:0]   mask_param;
    logic [10:0]   code_param;
    logic          filt_en;
    logic          rx_id_valid;
    logic [10:0]   rx_id;
    logic          rx_frame_ok;
    logic          rx_frame_err;
    logic          acc_rd;
    logic          acc_valid;
    logic [10:0]   acc_id;
    logic          acc_full;
    logic          ovf;
    logic          ovf_clr;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] rej_cnt;

    can_acceptance_filter #(
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .g_rst       (g_rst),
        .mask_param  (mask_param),
        .code_param  (code_param),
        .filt_en     (filt_en),
        .rx_id_valid (rx_id_valid),
        .rx_id       (rx_id),
        .rx_frame_ok (rx_frame_ok),
        .rx_frame_err(rx_frame_err),
        .acc_rd      (acc_rd),
        .acc_valid   (acc_valid),
        .acc_id      (acc_id),
        .acc_full    (acc_full),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .acc_cnt     (acc_cnt),
        .rej_cnt     (rej_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [10:0] exp_q[$];
    int          m_acc;
    int          m_rej;
    bit          m_ovf;
    int          checks;
    int          errors;

    function automatic bit ref_match(input bit fe, input logic [10:0] id,
                                     input logic [10:0] code, input logic [10:0] mask);
        if (!fe) return 1'b1;
        for (int b = 0; b < 11; b++) begin
            if (mask[b] && (id[b] != code[b])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [10:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 11'h000;
        chk({tag, ".acc_valid"}, 32'(acc_valid), 32'(exp_q.size() != 0));
        chk({tag, ".acc_full"},  32'(acc_full),  32'(exp_q.size() == DEPTH));
        chk({tag, ".acc_id"},    32'(acc_id),    32'(head));
        chk({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
        chk({tag, ".acc_cnt"},   32'(acc_cnt),   32'(m_acc));
        chk({tag, ".rej_cnt"},   32'(rej_cnt),   32'(m_rej));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model effect of a committed accepted ID (after any same-cycle pop).
    task automatic model_accept(input logic [10:0] id, input bit clr);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(id);
            m_acc = sat(m_acc);
            if (clr) m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected ID.
    always @(negedge clk) begin
        if (!g_rst && acc_rd && acc_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_head: got 0x%0h expected empty queue at %0t", acc_id, $time);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if (acc_id !== e) begin
                    errors++;
                    $display("FAIL pop_head: got 0x%0h expected 0x%0h at %0t", acc_id, e, $time);
                end
            end
        end
    end

    task automatic do_reset();
        g_rst = 1'b1;
        rx_id_valid = 1'b0; rx_frame_ok = 1'b0; rx_frame_err = 1'b0;
        acc_rd = 1'b0; ovf_clr = 1'b0;
        exp_q.delete();
        m_acc = 0; m_rej = 0; m_ovf = 1'b0;
        tick();
        tick();
        g_rst = 1'b0;
        tick();
    endtask

    // One frame: ID report, optional param change, end pulse(s), then the commit cycle.
    task automatic frame(input logic [10:0] id, input bit ok, input bit err,
                         input bit rd_commit, input bit clr_commit, input bit chg_params);
        bit m;
        tick();
        rx_id_valid = 1'b1;
        rx_id = id;
        m = ref_match(filt_en, id, code_param, mask_param);
        tick();
        rx_id_valid = 1'b0;
        if (chg_params) begin
            code_param = 11'($urandom);
            mask_param = 11'($urandom) & 11'($urandom);
        end
        repeat ($urandom_range(0, 1)) tick();
        rx_frame_ok = ok;
        rx_frame_err = err;
        tick();
        rx_frame_ok = 1'b0;
        rx_frame_err = 1'b0;
        if (ok && !err && !m) m_rej = sat(m_rej);
        chk("rej_cnt_after_eof", 32'(rej_cnt), 32'(m_rej));
        chk("valid_in_commit_cycle", 32'(acc_valid), 32'(exp_q.size() != 0));
        acc_rd = rd_commit;
        ovf_clr = clr_commit;
        tick();
        acc_rd = 1'b0;
        ovf_clr = 1'b0;
        if (ok && !err && m) model_accept(id, clr_commit);
        else if (clr_commit) m_ovf = 1'b0;
        check_outputs("frame");
    endtask

    // Frame B's ID report lands in the cycle right after frame A's end pulse.
    task automatic b2b(input logic [10:0] id_a, input logic [10:0] id_b);
        bit ma;
        bit mb;
        tick();
        rx_id_valid = 1'b1; rx_id = id_a;
        ma = ref_match(filt_en, id_a, code_param, mask_param);
        tick();
        rx_id_valid = 1'b0;
        rx_frame_ok = 1'b1;
        tick();
        rx_frame_ok = 1'b0;
        if (!ma) m_rej = sat(m_rej);
        chk("b2b_rej_a", 32'(rej_cnt), 32'(m_rej));
        rx_id_valid = 1'b1; rx_id = id_b;
        mb = ref_match(filt_en, id_b, code_param, mask_param);
        tick();
        rx_id_valid = 1'b0;
        if (ma) model_accept(id_a, 1'b0);
        check_outputs("b2b_a");
        rx_frame_ok = 1'b1;
        tick();
        rx_frame_ok = 1'b0;
        if (!mb) m_rej = sat(m_rej);
        tick();
        if (mb) model_accept(id_b, 1'b0);
        check_outputs("b2b_b");
    endtask

    task automatic pop_one();
        chk("valid_before_pop", 32'(acc_valid), 32'(exp_q.size() != 0));
        acc_rd = 1'b1;
        tick();
        acc_rd = 1'b0;
        check_outputs("pop");
    endtask

    task automatic clr();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        chk("ovf_after_clr", 32'(ovf), 32'(0));
    endtask

    initial begin
        logic [10:0] id;
        int          r;
        int          o;
        checks = 0;
        errors = 0;
        mask_param = 11'h7F0;
        code_param = 11'h123;
        filt_en = 1'b1;
        rx_id = '0;
        do_reset();
        check_outputs("reset");

        // Match then reject
        frame(11'h125, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_acc_id", 32'(acc_id), 32'h125);
        chk("tp_acc_cnt", 32'(acc_cnt), 32'd1);
        frame(11'h133, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_rej_cnt", 32'(rej_cnt), 32'd1);
        // Error wins over ok
        frame(11'h120, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Bypass
        filt_en = 1'b0; mask_param = 11'h7FF; code_param = 11'h000;
        frame(11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_one();
        chk("tp_bypass_head", 32'(acc_id), 32'h7FF);
        pop_one();
        pop_one();
        // Overflow, clear, drain in order
        for (int k = 0; k < 5; k++) frame(11'(16 + k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp_ovf", 32'(ovf), 32'd1);
        chk("tp_full", 32'(acc_full), 32'd1);
        clr();
        for (int k = 0; k < 4; k++) pop_one();
        chk("tp_drained", 32'(acc_valid), 32'd0);
        // Full with pop in the commit cycle, then a drop coinciding with ovf_clr
        for (int k = 0; k < 4; k++) frame(11'(32 + k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(11'h055, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(11'h066, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr_vs_drop", 32'(ovf), 32'd1);
        clr();
        for (int k = 0; k < 4; k++) pop_one();
        // Snapshot of params at the ID report
        filt_en = 1'b1; mask_param = 11'h7F0; code_param = 11'h123;
        frame(11'h12A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        filt_en = 1'b1; mask_param = 11'h7F0; code_param = 11'h123;
        // Back-to-back frames
        b2b(11'h121, 11'h12F);
        b2b(11'h133, 11'h125);
        // Reset mid-frame with two queued entries
        while (exp_q.size() > 2) pop_one();
        tick();
        rx_id_valid = 1'b1; rx_id = 11'h124;
        tick();
        rx_id_valid = 1'b0;
        g_rst = 1'b1;
        #1;
        exp_q.delete(); m_acc = 0; m_rej = 0; m_ovf = 1'b0;
        check_outputs("mid_reset");
        tick();
        g_rst = 1'b0;
        tick();
        rx_frame_ok = 1'b1;
        tick();
        rx_frame_ok = 1'b0;
        tick();
        tick();
        check_outputs("ok_after_reset");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                filt_en = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 1) == 1)
                    id = code_param ^ (11'($urandom) & ~mask_param);
                else
                    id = 11'($urandom);
                o = $urandom_range(0, 9);
                frame(id, (o < 7) || (o == 8), (o == 7) || (o == 8),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 4) == 0);
            end else if (r < 9) begin
                pop_one();
            end else begin
                clr();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_acceptance_filter.md
# can_acceptance_filter

Receive-path acceptance filter sitting directly downstream of the parameter registry. Consumes the registry's `mask_param`/`code_param` outputs and the receive controller's per-frame identifier reports. Decides per frame whether the 11-bit base identifier is accepted, commits accepted IDs to a small FWFT queue only after the frame ends without error, and keeps saturating accept/reject statistics.

## Interface
- `FIFO_DEPTH`, default 4: accepted-ID queue depth; power of two, ≥ 2.
- `CNT_W`, default 16: width of the accept and reject counters.
- `clk` in 1: clock.
- `g_rst` in 1: reset, asynchronous, active-high.
- `mask_param` in 11: compare mask; bit = 1 means that ID bit must match `code_param`.
- `code_param` in 11: acceptance code.
- `filt_en` in 1: 1 = filtering active; 0 = accept every error-free frame.
- `rx_id_valid` in 1: single-cycle pulse; `rx_id` is valid at end of the arbitration field.
- `rx_id` in 11: received base identifier.
- `rx_frame_ok` in 1: single-cycle pulse; the current frame completed without error.
- `rx_frame_err` in 1: single-cycle pulse; the current frame was aborted by an error.
- `acc_rd` in 1: pop the queue head; ignored when empty.
- `acc_valid` out 1: queue not empty.
- `acc_id` out 11: queue head (FWFT); 0 when empty.
- `acc_full` out 1: queue full.
- `ovf` out 1: sticky; an accepted ID was dropped because the queue was full.
- `ovf_clr` in 1: clears `ovf`. If it coincides with a new drop, `ovf` stays 1.
- `acc_cnt` out CNT_W: accepted-and-queued frame count; saturates at all-ones.
- `rej_cnt` out CNT_W: count of error-free frames that failed the filter; saturates.

## Operation
- Match rule: `match = !filt_en || ((rx_id ^ code_param) & mask_param) == 0`.
  - Evaluated in the `rx_id_valid` cycle using the `mask_param`/`code_param` values present in that cycle.
  - The ID and the match result are snapshotted then. Parameter changes later in the frame do not affect that frame.
- FSM states:
  - `IDLE`: on `rx_id_valid`, capture ID and match, go to `WAIT_EOF`.
  - `WAIT_EOF`:
    - On `rx_frame_err`: discard the frame, no counter change, go to `IDLE`. Error wins if it coincides with `rx_frame_ok`.
    - On `rx_frame_ok` with match: go to `COMMIT`.
    - On `rx_frame_ok` without match: increment `rej_cnt`, go to `IDLE`.
    - On another `rx_id_valid` with no end pulse in the same cycle: silently discard the pending frame, recapture, stay in `WAIT_EOF`.
  - `COMMIT` (one cycle):
    - If not full, or full with `acc_rd` in the same cycle: push the ID and increment `acc_cnt`.
    - Otherwise: drop the ID, set `ovf`, leave `acc_cnt` unchanged.
    - Next state is `WAIT_EOF` if `rx_id_valid` arrives in this cycle (capture it), else `IDLE`.
- `rx_frame_ok`/`rx_frame_err` in `IDLE` or `COMMIT`: ignored.
- Queue rules:
  - Simultaneous push and pop: both take effect.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `acc_rd` while empty: no effect, no underflow.
- Reset, including mid-frame: state `IDLE`, queue emptied, pending frame lost. All outputs are 0: `acc_valid`, `acc_id`, `acc_full`, `ovf`, `acc_cnt`, `rej_cnt`.

## Timing
- `rx_frame_ok` at cycle N (match) → `COMMIT` at N+1 → `acc_valid`=1, `acc_id` valid, `acc_cnt` incremented at N+2.
- Reject path: `rej_cnt` updated at N+1.
- `acc_rd` at cycle M → head advances and `acc_valid`/`acc_full` update at M+1.
- All outputs registered; no combinational path from inputs to outputs.
- Minimum frame spacing supported: `rx_id_valid` may arrive in the cycle right after `rx_frame_ok`/`rx_frame_err`, or in the `COMMIT` cycle.

## Structure
- Shared package `can_rx_pkg` holds:
  - `ID_W` = 11.
  - The filter state enum (`IDLE`, `WAIT_EOF`, `COMMIT`).
  - The match function, for reuse by a future extended-ID filter.
- One sub-module, `accept_fifo`: synchronous FWFT FIFO parameterised by depth and width. It provides push, pop, full, empty and the head word.
- FSM, match logic and counters live in the top level.

## Test plan
- Match and reject: `code`=0x123, `mask`=0x7F0, `filt_en`=1.
  - `rx_id` 0x125 then `rx_frame_ok` → `acc_valid` two cycles after ok, `acc_id`=0x125, `acc_cnt`=1.
  - Next frame 0x133 + ok → `rej_cnt`=1, queue unchanged.
- Error abort: `rx_id` 0x120 then `rx_frame_ok` and `rx_frame_err` in the same cycle → nothing queued, both counters unchanged.
- Bypass: `filt_en`=0, `mask`=0x7FF, `code`=0, `rx_id` 0x7FF + ok → accepted, `acc_id`=0x7FF.
- Overflow: 5 accepted frames with no `acc_rd` at depth 4 → `acc_full`=1, `ovf`=1, `acc_cnt`=4.
  - Then `ovf_clr` → `ovf`=0.
  - Then 4 pops return the first 4 IDs in order; `acc_valid`=0 afterwards.
- Snapshot and back-to-back:
  - Change `code` after `rx_id_valid` → decision uses the old code.
  - New `rx_id_valid` during `COMMIT` → both frames are handled correctly.
- Reset mid-frame: assert `g_rst` in `WAIT_EOF` with 2 queued entries → all outputs 0; a later `rx_frame_ok` alone produces no push.
